// File: rtl/ledseq_if.sv
// rtl/ledseq_if.sv - pipelined Wishbone bus used for the ledseq config port and LED master port
interface ledseq_if #(
   parameter int AW = 4
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic [3:0]    sel;
   logic          stall;
   logic          ack;
   logic          err;
   logic [31:0]   rdata;

   modport master (output cyc, stb, we, addr, wdata, sel, input stall, ack, err, rdata);
   modport slave  (input cyc, stb, we, addr, wdata, sel, output stall, ack, err, rdata);
endinterface

// File: rtl/ledseq.sv
// rtl/ledseq.sv - Wishbone LED pattern sequencer; define LEDSEQ_TIMEOUT_EN for the master ack timeout
module ledseq #(
   parameter int NLEDS     = 8,
   parameter int LGPERIOD  = 24,
   parameter int LGTIMEOUT = 10
) (
   input  logic     i_clk,
   input  logic     i_reset_n,
   ledseq_if.slave  wb,
   ledseq_if.master m,
   output logic     o_int
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACKWAIT, S_WAIT} state_t;

   localparam logic [7:0] LED_MASK = 8'hFF >> (8 - NLEDS);

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdat,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
      return r;
   endfunction

   state_t              state_q, state_d;
   logic                en_q, en_d, oneshot_q, oneshot_d, err_q, err_d;
   logic [2:0]          last_q, last_d, idx_q, idx_d;
   logic [LGPERIOD-1:0] period_q, period_d, cnt_q, cnt_d;
   logic [15:0]         tbl_q [8];
   logic [15:0]         tbl_d [8];
   logic                m_cyc_q, m_cyc_d, m_stb_q, m_stb_d, int_q, int_d;
   logic [15:0]         m_data_q, m_data_d;
   logic                ack_q;
   logic [31:0]         rdata_q, rd_data;
   logic                wr_en, busy, resp_err, seq_end, en_clr, err_set;
   logic                tmo_fire;

`ifdef LEDSEQ_TIMEOUT_EN
   logic [LGTIMEOUT-1:0] tmo_q, tmo_d;
   logic                 unused_sink;

   // Counter is held at zero outside ACKWAIT, so entry always starts a fresh count.
   always_comb tmo_d = (state_q == S_ACKWAIT) ? tmo_q + LGTIMEOUT'(1) : '0;
   assign tmo_fire    = (state_q == S_ACKWAIT) && (&tmo_q);
   assign unused_sink = ^m.rdata;

   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) tmo_q <= '0;
      else            tmo_q <= tmo_d;
`else
   logic unused_sink;
   assign tmo_fire    = 1'b0;
   assign unused_sink = ^{m.rdata, LGTIMEOUT[0]};
`endif

   assign busy     = (state_q != S_IDLE);
   assign resp_err = (state_q == S_ACKWAIT) && (m.err || tmo_fire);
   assign seq_end  = (idx_q == last_q) && oneshot_q;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (en_q) state_d = S_ISSUE;
         S_ISSUE:   if (!m.stall) state_d = S_ACKWAIT;
         S_ACKWAIT: begin
            if (resp_err)                 state_d = S_IDLE;
            else if (m.ack) begin
               if (seq_end || !en_q)      state_d = S_IDLE;
               else if (period_q == '0)   state_d = S_ISSUE;
               else                       state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!en_q)                         state_d = S_IDLE;
            else if (cnt_q == LGPERIOD'(1))    state_d = S_ISSUE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs and datapath; bus outputs are registered from the next state
   always_comb begin
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      m_data_d = m_data_q;
      int_d    = 1'b0;
      en_clr   = 1'b0;
      err_set  = 1'b0;
      m_cyc_d  = (state_d == S_ISSUE) || (state_d == S_ACKWAIT);
      m_stb_d  = (state_d == S_ISSUE);
      case (state_q)
         S_IDLE: if (en_q) idx_d = '0;
         S_ACKWAIT: begin
            if (resp_err) begin
               err_set = 1'b1;
               en_clr  = 1'b1;
               int_d   = 1'b1;
            end else if (m.ack) begin
               if (seq_end) begin
                  en_clr = 1'b1;
                  int_d  = 1'b1;
               end else begin
                  idx_d = (idx_q == last_q) ? 3'd0 : idx_q + 3'd1;
                  cnt_d = period_q;
               end
            end
         end
         S_WAIT:  cnt_d = cnt_q - LGPERIOD'(1);
         default: ;
      endcase
      if ((state_d == S_ISSUE) && (state_q != S_ISSUE)) m_data_d = tbl_q[idx_d];
   end

   // Register file writes; sequencer-driven EN clear and ERR set take priority
   always_comb begin
      wr_en     = wb.cyc && wb.stb && wb.we;
      en_d      = en_q;
      oneshot_d = oneshot_q;
      last_d    = last_q;
      period_d  = period_q;
      err_d     = err_q;
      for (int i = 0; i < 8; i++) tbl_d[i] = tbl_q[i];
      if (wr_en) begin
         if (wb.addr[3]) begin
            tbl_d[wb.addr[2:0]] = 16'(merge(32'(tbl_q[wb.addr[2:0]]), wb.wdata, wb.sel))
                                  & {LED_MASK, LED_MASK};
         end else begin
            case (wb.addr[2:0])
               3'd0: begin
                  if (wb.sel[0]) begin
                     en_d      = wb.wdata[0];
                     oneshot_d = wb.wdata[1];
                  end
                  if (wb.sel[1]) last_d = wb.wdata[10:8];
               end
               3'd1:    period_d = LGPERIOD'(merge(32'(period_q), wb.wdata, wb.sel));
               3'd2:    if (wb.sel[0] && wb.wdata[5]) err_d = 1'b0;
               default: ;
            endcase
         end
      end
      if (en_clr)  en_d  = 1'b0;
      if (err_set) err_d = 1'b1;
   end

   always_comb begin
      rd_data = 32'h0;
      if (wb.addr[3]) rd_data = {16'h0, tbl_q[wb.addr[2:0]]};
      else begin
         case (wb.addr[2:0])
            3'd0:    rd_data = {21'h0, last_q, 6'h0, oneshot_q, en_q};
            3'd1:    rd_data = 32'(period_q);
            3'd2:    rd_data = {26'h0, err_q, busy, 1'b0, idx_q};
            default: rd_data = 32'h0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= S_IDLE;
         en_q      <= 1'b0;
         oneshot_q <= 1'b0;
         last_q    <= '0;
         period_q  <= '0;
         err_q     <= 1'b0;
         idx_q     <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < 8; i++) tbl_q[i] <= '0;
         m_cyc_q   <= 1'b0;
         m_stb_q   <= 1'b0;
         m_data_q  <= '0;
         int_q     <= 1'b0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         oneshot_q <= oneshot_d;
         last_q    <= last_d;
         period_q  <= period_d;
         err_q     <= err_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         for (int i = 0; i < 8; i++) tbl_q[i] <= tbl_d[i];
         m_cyc_q   <= m_cyc_d;
         m_stb_q   <= m_stb_d;
         m_data_q  <= m_data_d;
         int_q     <= int_d;
         ack_q     <= wb.cyc && wb.stb;
         if (wb.cyc && wb.stb) rdata_q <= rd_data;
      end
   end

   assign wb.stall = 1'b0;
   assign wb.ack   = ack_q;
   assign wb.err   = 1'b0;
   assign wb.rdata = rdata_q;

   assign m.cyc   = m_cyc_q;
   assign m.stb   = m_stb_q;
   assign m.we    = m_cyc_q;
   assign m.addr  = '0;
   assign m.wdata = {16'h0, m_data_q};
   assign m.sel   = 4'b0011;
   assign o_int   = int_q;
endmodule

// File: tb/tb_ledseq.sv
// tb/tb_ledseq.sv - scoreboard testbench for ledseq
module tb_ledseq;
   logic i_clk = 1'b0;
   logic i_reset_n;
   logic o_int;
   int   cyc_n = 0;

   ledseq_if #(.AW(4)) wb ();
   ledseq_if #(.AW(4)) m ();

   ledseq #(.NLEDS(8), .LGPERIOD(24), .LGTIMEOUT(10)) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .wb        (wb),
      .m         (m),
      .o_int     (o_int)
   );

   int          checks = 0, errors = 0;
   logic [31:0] exp_q [$];
   int          wr_count = 0, resp_n = 0, err_at = 0, stall_left = 0;
   int          int_count = 0, last_resp_cyc = 0, last_acc_cyc = -1, exp_gap = 0;
   bit          noack = 1'b0, chk_int_lat = 1'b1;

   initial forever begin
      #5 i_clk = 1'b1;
      cyc_n++;
      #5 i_clk = 1'b0;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // LED-register slave model: pops the scoreboard on each accepted write
   initial begin
      logic acc, do_err;
      logic [31:0] e;
      m.stall = 1'b0; m.ack = 1'b0; m.err = 1'b0; m.rdata = '0;
      forever begin
         @(negedge i_clk);
         acc    = i_reset_n && m.cyc && m.stb && !m.stall;
         do_err = 1'b0;
         if (i_reset_n && m.stb && m.stall) begin
            if (exp_q.size() == 0) check("stall_expected", 32'(exp_q.size() > 0), 32'd1);
            else                   check("stall_data", m.wdata, exp_q[0]);
         end
         if (acc) begin
            wr_count++;
            resp_n++;
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("m_data", m.wdata, e);
            end
            check("m_sel", 32'(m.sel), 32'h3);
            check("m_we", 32'(m.we), 32'h1);
            if (exp_gap > 0 && last_acc_cyc >= 0) check("stb_gap", cyc_n - last_acc_cyc, exp_gap);
            last_acc_cyc = cyc_n;
            do_err = (resp_n == err_at);
         end
         @(posedge i_clk);
         #1;
         m.ack = acc && !noack && !do_err;
         m.err = acc && do_err;
         if (acc) last_resp_cyc = cyc_n;
         m.stall = m.stb && (stall_left > 0);
         if (m.stall) stall_left--;
      end
   end

   initial forever begin
      @(negedge i_clk);
      if (o_int) begin
         int_count++;
         if (chk_int_lat) check("int_latency", cyc_n - last_resp_cyc, 1);
      end
   end

   task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      @(posedge i_clk); #1;
      wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.addr = a; wb.wdata = d; wb.sel = s;
      @(posedge i_clk); #1;
      wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
      @(negedge i_clk);
      check("wb_wr_ack", 32'(wb.ack), 32'h1);
   endtask

   task automatic wb_read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
      @(posedge i_clk); #1;
      wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = a; wb.sel = 4'hF;
      @(posedge i_clk); #1;
      wb.cyc = 1'b0; wb.stb = 1'b0;
      @(negedge i_clk);
      check("wb_rd_ack", 32'(wb.ack), 32'h1);
      check(tag, wb.rdata, exp);
   endtask

   task automatic regs_zero(input string tag);
      wb_read_check({tag, "_ctrl"}, 4'd0, 32'h0);
      wb_read_check({tag, "_period"}, 4'd1, 32'h0);
      wb_read_check({tag, "_status"}, 4'd2, 32'h0);
      for (int i = 8; i < 16; i++) wb_read_check({tag, "_table"}, 4'(i), 32'h0);
   endtask

   task automatic wait_writes(input int n, input int budget);
      int k = 0;
      while (wr_count < n && k < budget) begin
         @(negedge i_clk);
         k++;
      end
      check("wait_writes", wr_count, n);
   endtask

   task automatic start_test(input int gap);
      wr_count = 0; resp_n = 0; int_count = 0; last_acc_cyc = -1; exp_gap = gap;
   endtask

   initial begin
      int k;
      i_reset_n = 1'b0;
      wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.addr = '0; wb.wdata = '0; wb.sel = '0;
      repeat (3) @(negedge i_clk);
      check("rst_m_cyc", 32'(m.cyc), 32'h0);
      check("rst_m_stb", 32'(m.stb), 32'h0);
      check("rst_int", 32'(o_int), 32'h0);
      check("rst_wb_ack", 32'(wb.ack), 32'h0);
      check("rst_wb_data", wb.rdata, 32'h0);
      @(posedge i_clk); #1 i_reset_n = 1'b1;
      regs_zero("rst");

      // Two-entry loop, PERIOD=3
      wb_write(4'd8, 32'hFFFF0F05, 4'hF);
      wb_read_check("tbl_upper_zero", 4'd8, 32'h0000_0F05);
      wb_write(4'd9, 32'h0000F0A0, 4'hF);
      wb_write(4'd1, 32'd3, 4'hF);
      start_test(5);
      exp_q.push_back(32'h0F05); exp_q.push_back(32'hF0A0);
      exp_q.push_back(32'h0F05); exp_q.push_back(32'hF0A0);
      wb_write(4'd0, 32'h101, 4'hF);
      check("en_stb_lat0", 32'(m.stb), 32'h0);
      @(negedge i_clk);
      check("en_to_stb", 32'(m.stb), 32'h1);
      wait_writes(4, 100);
      wb_write(4'd0, 32'h100, 4'hF);
      repeat (10) @(negedge i_clk);
      check("loop_q_empty", exp_q.size(), 0);
      check("loop_count", wr_count, 4);
      wb_read_check("loop_status", 4'd2, 32'h0);

      // One-shot, LAST=2
      wb_write(4'd10, 32'h3C3C, 4'hF);
      start_test(5);
      exp_q.push_back(32'h0F05); exp_q.push_back(32'hF0A0); exp_q.push_back(32'h3C3C);
      wb_write(4'd0, 32'h203, 4'hF);
      wait_writes(3, 100);
      repeat (10) @(negedge i_clk);
      check("os_count", wr_count, 3);
      check("os_int", int_count, 1);
      wb_read_check("os_ctrl", 4'd0, 32'h202);
      wb_read_check("os_status", 4'd2, 32'h2);

      // Byte enables and stall
      wb_write(4'd1, 32'hFFFFFF07, 4'b0001);
      wb_read_check("period_sel", 4'd1, 32'h7);
      wb_write(4'd8, 32'h0000AA55, 4'b0010);
      wb_read_check("tbl_sel", 4'd8, 32'hAA05);
      start_test(0);
      exp_q.push_back(32'hAA05);
      stall_left = 4;
      wb_write(4'd0, 32'h003, 4'hF);
      wait_writes(1, 50);
      repeat (10) @(negedge i_clk);
      check("stall_count", wr_count, 1);
      check("stall_used", stall_left, 0);
      check("stall_int", int_count, 1);

      // Error on the second write, PERIOD=0
      wb_write(4'd8, 32'h0F05, 4'hF);
      wb_write(4'd1, 32'h0, 4'hF);
      start_test(2);
      err_at = 2;
      exp_q.push_back(32'h0F05); exp_q.push_back(32'hF0A0);
      wb_write(4'd0, 32'h101, 4'hF);
      wait_writes(2, 50);
      repeat (20) @(negedge i_clk);
      err_at = 0;
      check("err_count", wr_count, 2);
      check("err_int", int_count, 1);
      wb_read_check("err_status", 4'd2, 32'h21);
      wb_read_check("err_ctrl", 4'd0, 32'h100);
      wb_write(4'd2, 32'h20, 4'hF);
      wb_read_check("err_clear", 4'd2, 32'h01);

      // No response from the LED slave
      start_test(0);
      noack = 1'b1;
      chk_int_lat = 1'b0;
      exp_q.push_back(32'h0F05);
      wb_write(4'd0, 32'h003, 4'hF);
      wait_writes(1, 20);
`ifdef LEDSEQ_TIMEOUT_EN
      k = 0;
      while (m.cyc && k < 1200) begin
         @(negedge i_clk);
         k++;
      end
      check("tmo_ackwait_cycles", cyc_n - last_acc_cyc - 1, 1024);
      repeat (3) @(negedge i_clk);
      check("tmo_int", int_count, 1);
      wb_read_check("tmo_status", 4'd2, 32'h20);
`else
      repeat (1100) @(negedge i_clk);
      check("notmo_cyc_high", 32'(m.cyc), 32'h1);
      check("notmo_int", int_count, 0);
      wb_read_check("notmo_status", 4'd2, 32'h10);
`endif
      noack = 1'b0;
      chk_int_lat = 1'b1;

      // Reset while the master holds a stalled strobe
      @(negedge i_clk); i_reset_n = 1'b0;
      @(posedge i_clk); #1 i_reset_n = 1'b1;
      exp_q.delete();
      wb_write(4'd8, 32'h0F05, 4'hF);
      start_test(0);
      stall_left = 1000;
      exp_q.push_back(32'h0F05);
      wb_write(4'd0, 32'h001, 4'hF);
      k = 0;
      while (!m.stb && k < 10) begin
         @(negedge i_clk);
         k++;
      end
      check("stb_before_rst", 32'(m.stb), 32'h1);
      repeat (2) @(negedge i_clk);
      #2 i_reset_n = 1'b0;
      #1;
      check("async_rst_cyc", 32'(m.cyc), 32'h0);
      check("async_rst_stb", 32'(m.stb), 32'h0);
      stall_left = 0;
      exp_q.delete();
      @(posedge i_clk); #1 i_reset_n = 1'b1;
      regs_zero("post_rst");
      check("post_rst_writes", wr_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
